// File: rtl/alu_result_stage.sv
// fifo: generic valid/ready FIFO, power-of-two DEPTH, registered occupancy.
// Latency: a push is visible at pop_vld/pop_dat in the following cycle.
// Backpressure: push_rdy depends only on stored occupancy, so it never sees pop_rdy.
module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  output logic             push_rdy,
  output logic             pop_vld,
  output logic [WIDTH-1:0] pop_dat,
  input  logic             pop_rdy
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  assign push_rdy = (count < (AW+1)'(DEPTH));
  assign pop_vld  = (count != '0);
  assign pop_dat  = mem[rd_ptr];
  assign push     = push_vld && push_rdy;
  assign pop      = pop_vld && pop_rdy;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is left unreset; consumers only look at it while pop_vld is high.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end
endmodule

// alu_result_stage: registers ALU results with N/Z/V flags into a 2-deep FIFO, counts overflows.
// Latency: one cycle from accepted push to out_valid; no input-to-output bypass.
// Backpressure: in_ready = occupancy < 2 from registered state only.
module alu_result_stage #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 5,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [DATA_W-1:0] in_port_a,
  input  logic [DATA_W-1:0] in_port_b,
  input  logic [3:0]        in_opcode,
  input  logic [DEST_W-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [DEST_W-1:0] out_dest,
  output logic              out_negative,
  output logic              out_zero,
  output logic              out_overflow,
  input  logic              ovf_clr,
  output logic [CNT_W-1:0]  ovf_count
);
  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [DEST_W-1:0] dest;
    logic              negative;
    logic              zero;
    logic              overflow;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  entry_t in_ent;
  entry_t head;
  logic   in_ovf;
  logic   push;
  logic   a_msb;
  logic   b_msb;
  logic   r_msb;

  assign a_msb = in_port_a[DATA_W-1];
  assign b_msb = in_port_b[DATA_W-1];
  assign r_msb = in_result[DATA_W-1];

  // Only add (8) and sub (9) can overflow; every other opcode reports V=0.
  always_comb begin
    in_ovf = 1'b0;
    case (in_opcode)
      4'd8:    in_ovf = (a_msb == b_msb) && (r_msb != a_msb);
      4'd9:    in_ovf = (a_msb != b_msb) && (r_msb != a_msb);
      default: in_ovf = 1'b0;
    endcase
  end

  assign in_ent.result   = in_result;
  assign in_ent.dest     = in_dest;
  assign in_ent.negative = r_msb;
  assign in_ent.zero     = (in_result == '0);
  assign in_ent.overflow = in_ovf;

  fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (2)
  ) u_fifo (
    .clk      (clk),
    .n_rst    (n_rst),
    .push_vld (in_valid),
    .push_dat (in_ent),
    .push_rdy (in_ready),
    .pop_vld  (out_valid),
    .pop_dat  (head),
    .pop_rdy  (out_ready)
  );

  assign push = in_valid && in_ready;

  assign out_result   = out_valid ? head.result   : '0;
  assign out_dest     = out_valid ? head.dest     : '0;
  assign out_negative = out_valid && head.negative;
  assign out_zero     = out_valid && head.zero;
  assign out_overflow = out_valid && head.overflow;

  // Clear has priority over a same-cycle overflow push.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ovf_count <= '0;
    end else if (ovf_clr) begin
      ovf_count <= '0;
    end else if (push && in_ovf && (ovf_count != {CNT_W{1'b1}})) begin
      ovf_count <= ovf_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage with a queue-based reference model checked every cycle.
module tb_alu_result_stage;
  localparam int CNT_W = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_result = '0;
  logic [31:0] in_port_a = '0;
  logic [31:0] in_port_b = '0;
  logic [3:0]  in_opcode = '0;
  logic [4:0]  in_dest = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [4:0]  out_dest;
  logic        out_negative;
  logic        out_zero;
  logic        out_overflow;
  logic        ovf_clr = 1'b0;
  logic [CNT_W-1:0] ovf_count;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  alu_result_stage #(.DATA_W(32), .DEST_W(5), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_port_a    (in_port_a),
    .in_port_b    (in_port_b),
    .in_opcode    (in_opcode),
    .in_dest      (in_dest),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_dest     (out_dest),
    .out_negative (out_negative),
    .out_zero     (out_zero),
    .out_overflow (out_overflow),
    .ovf_clr      (ovf_clr),
    .ovf_count    (ovf_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of expected entries and an integer counter.
  typedef struct {
    logic [31:0] r;
    logic [4:0]  d;
    bit          n;
    bit          z;
    bit          v;
  } exp_t;

  exp_t mq[$];
  int   mcnt = 0;

  function automatic bit neg32(input logic [31:0] x);
    return $signed(x) < 0;
  endfunction

  function automatic bit model_ovf(input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] r, input logic [3:0] op);
    if (op == 4'd8) return (neg32(a) == neg32(b)) && (neg32(r) != neg32(a));
    if (op == 4'd9) return (neg32(a) != neg32(b)) && (neg32(r) != neg32(a));
    return 1'b0;
  endfunction

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mq.delete();
      mcnt = 0;
    end else begin
      bit   pu;
      bit   po;
      exp_t e;
      pu = (in_valid === 1'b1) && (mq.size() < 2);
      po = (out_ready === 1'b1) && (mq.size() > 0);
      e.r = in_result;
      e.d = in_dest;
      e.n = neg32(in_result);
      e.z = (in_result == 32'd0);
      e.v = model_ovf(in_port_a, in_port_b, in_result, in_opcode);
      if (ovf_clr) mcnt = 0;
      else if (pu && e.v && mcnt < MAXC) mcnt = mcnt + 1;
      if (po) void'(mq.pop_front());
      if (pu) mq.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      exp_t h;
      h = '{r: 32'd0, d: 5'd0, n: 1'b0, z: 1'b0, v: 1'b0};
      if (mq.size() > 0) h = mq[0];
      chk("m_in_ready",  in_ready,     mq.size() < 2);
      chk("m_out_valid", out_valid,    mq.size() > 0);
      chk("m_result",    out_result,   h.r);
      chk("m_dest",      out_dest,     h.d);
      chk("m_neg",       out_negative, h.n);
      chk("m_zero",      out_zero,     h.z);
      chk("m_ovf",       out_overflow, h.v);
      chk("m_ovf_count", ovf_count,    mcnt);
    end
  end

  task automatic set_in(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                        input logic [31:0] r, input logic [4:0] d);
    in_port_a = a;
    in_port_b = b;
    in_opcode = op;
    in_result = r;
    in_dest   = d;
  endtask

  // Called just after a negedge; returns at the negedge following acceptance.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                      input logic [31:0] r, input logic [4:0] d);
    bit done;
    done = 1'b0;
    set_in(a, b, op, r, d);
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (in_ready) done = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1 within 20 cycles");
    end
  endtask

  task automatic drain1;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  logic [31:0] popped[$];
  bit          acc;

  initial begin
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // Reset state.
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ovf_count", ovf_count, 0);

    // Single plain add.
    send(32'd5, 32'd3, 4'd8, 32'd8, 5'd3);
    chk("add_valid", out_valid, 1);
    chk("add_result", out_result, 32'd8);
    chk("add_dest", out_dest, 5'd3);
    chk("add_nzv", {out_negative, out_zero, out_overflow}, 3'b000);
    drain1();
    chk("add_drained", out_valid, 0);

    // Signed add overflow.
    send(32'h7FFF_FFFF, 32'd1, 4'd8, 32'h8000_0000, 5'd4);
    chk("addovf_nv", {out_negative, out_overflow}, 2'b11);
    chk("addovf_cnt", ovf_count, 1);
    drain1();

    // Signed sub overflow, then zero result, non-overflowing sub, undefined opcode.
    send(32'h8000_0000, 32'd1, 4'd9, 32'h7FFF_FFFF, 5'd5);
    chk("subovf_nv", {out_negative, out_overflow}, 2'b01);
    chk("subovf_cnt", ovf_count, 2);
    drain1();
    send(32'd9, 32'd6, 4'd4, 32'd0, 5'd6);
    chk("zero_zv", {out_zero, out_overflow}, 2'b10);
    drain1();
    send(32'd5, 32'd3, 4'd9, 32'd2, 5'd7);
    chk("sub_nov", out_overflow, 0);
    drain1();
    send(32'h7FFF_FFFF, 32'd1, 4'd10, 32'h8000_0000, 5'd8);
    chk("op10_nv", {out_negative, out_overflow}, 2'b10);
    drain1();

    // Backpressure: fill, hold a third, then release.
    send(32'd1, 32'd1, 4'd0, 32'd11, 5'd1);
    send(32'd1, 32'd1, 4'd0, 32'd22, 5'd2);
    set_in(32'd1, 32'd1, 4'd0, 32'd33, 5'd3);
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("full_in_ready", in_ready, 0);
    chk("full_head", out_result, 32'd11);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) popped.push_back(out_result);
      acc = in_valid && in_ready;
      @(negedge clk);
      if (acc) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    chk("bp_pop_count", popped.size(), 3);
    if (popped.size() == 3) begin
      chk("bp_order0", popped[0], 32'd11);
      chk("bp_order1", popped[1], 32'd22);
      chk("bp_order2", popped[2], 32'd33);
    end

    // Saturation of the 2-bit counter, then clear winning over an overflow push.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(32'h7FFF_FFFF, 32'd1, 4'd8, 32'h8000_0000, 5'(i));
    chk("sat_cnt", ovf_count, 3);
    set_in(32'h7FFF_FFFF, 32'd1, 4'd8, 32'h8000_0000, 5'd9);
    in_valid = 1'b1;
    ovf_clr = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    ovf_clr = 1'b0;
    chk("clr_cnt", ovf_count, 0);
    send(32'h8000_0000, 32'd1, 4'd9, 32'h7FFF_FFFF, 5'd10);
    chk("after_clr_cnt", ovf_count, 1);
    @(negedge clk);
    out_ready = 1'b0;

    // Asynchronous reset with two entries buffered.
    send(32'd1, 32'd2, 4'd8, 32'd3, 5'd11);
    send(32'd1, 32'd2, 4'd8, 32'd3, 5'd12);
    chk("pre_rst_full", in_ready, 0);
    #2 n_rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_ovf_count", ovf_count, 0);
    chk("mid_rst_result", out_result, 0);
    @(negedge clk);
    n_rst = 1'b1;
    send(32'd2, 32'd2, 4'd8, 32'd4, 5'd13);
    chk("post_rst_result", out_result, 32'd4);
    drain1();
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
